// File: rtl/cram_pkg.sv
// Shared types and constants for the colour RAM write path.
// Entry layout is {palette index, 16-bit colour word}.
package cram_pkg;

  localparam int CRAM_AW = 8;
  localparam int CRAM_DW = 16;
  localparam int CRAM_EW = CRAM_AW + CRAM_DW;

  localparam logic [1:0] CRAM_REG_ADDR = 2'd0;
  localparam logic [1:0] CRAM_REG_LO   = 2'd1;
  localparam logic [1:0] CRAM_REG_HI   = 2'd2;

  typedef struct packed {
    logic [CRAM_AW-1:0] addr;
    logic [CRAM_DW-1:0] data;
  } cram_entry_t;

  function automatic cram_entry_t cram_entry(
    input logic [CRAM_AW-1:0] addr,
    input logic [CRAM_DW-1:0] data
  );
    cram_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/cram_wr_fifo.sv
// Small synchronous FIFO with combinational head output.
// DEPTH must be a power of two so the pointers wrap naturally.
module cram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cram_wr_ctrl.sv
// Colour RAM write controller: CPU byte / DMA word writes -> FIFO -> CRAM.
// Define CRAM_AUTOINC_EN to post-increment ptr after each CPU high-byte push.
module cram_wr_ctrl
  import cram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_wr,
  input  logic [1:0]         cpu_reg,
  input  logic [7:0]         cpu_data,
  input  logic               dma_req,
  input  logic [CRAM_AW-1:0] dma_addr,
  input  logic [CRAM_DW-1:0] dma_data,
  output logic               dma_ack,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_data,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] ptr,
  output logic               busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DMA_LIM = CW'(FIFO_DEPTH - 2);

  logic        wr_addr;
  logic        wr_lo;
  logic        cpu_push;
  logic [7:0]  lo;

  logic        push;
  logic        pop;
  logic        empty;
  logic [CW-1:0] count;
  cram_entry_t din;
  cram_entry_t dout;

  always_comb begin
    wr_addr  = 1'b0;
    wr_lo    = 1'b0;
    cpu_push = 1'b0;
    if (cpu_wr) begin
      unique case (cpu_reg)
        CRAM_REG_ADDR: wr_addr  = 1'b1;
        CRAM_REG_LO:   wr_lo    = 1'b1;
        CRAM_REG_HI:   cpu_push = 1'b1;
        default: ;
      endcase
    end
  end

  // Holding the DMA to DEPTH-1 keeps one slot free for the CPU.
  assign dma_ack = rst_n & dma_req & ~cpu_push
                 & (count <= DMA_LIM);

  assign push = cpu_push | dma_ack;
  assign pop  = ~empty;

  always_comb begin
    din = cram_entry(dma_addr, dma_data);
    if (cpu_push) begin
      din = cram_entry(ptr, {cpu_data, lo});
    end
  end

  cram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CRAM_EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      lo  <= '0;
    end else begin
      if (wr_addr) begin
        ptr <= cpu_data;
      end
`ifdef CRAM_AUTOINC_EN
      else if (cpu_push) begin
        ptr <= ptr + 8'd1;
      end
`endif
      if (wr_lo) begin
        lo <= cpu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cram_we   <= 1'b0;
      cram_addr <= '0;
      cram_data <= '0;
    end else begin
      cram_we <= pop;
      if (pop) begin
        cram_addr <= dout.addr;
        cram_data <= dout.data;
      end
    end
  end

  assign busy = ~empty | cram_we;

endmodule

// File: tb/tb_cram_wr_ctrl.sv
// Self-checking bench for cram_wr_ctrl: vector table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_cram_wr_ctrl;
  import cram_pkg::*;

  localparam int DEPTH = 4;
`ifdef CRAM_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_wr;
  logic [1:0]  cpu_reg;
  logic [7:0]  cpu_data;
  logic        dma_req;
  logic [7:0]  dma_addr;
  logic [15:0] dma_data;
  logic        dma_ack;
  logic [7:0]  cram_addr;
  logic [15:0] cram_data;
  logic        cram_we;
  logic [7:0]  ptr;
  logic        busy;

  always #5 clk = ~clk;

  cram_wr_ctrl #(.FIFO_DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_wr    (cpu_wr),
    .cpu_reg   (cpu_reg),
    .cpu_data  (cpu_data),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_data  (dma_data),
    .dma_ack   (dma_ack),
    .cram_addr (cram_addr),
    .cram_data (cram_data),
    .cram_we   (cram_we),
    .ptr       (ptr),
    .busy      (busy)
  );

  int errs = 0;
  int checks = 0;

  logic [23:0] mq[$];
  logic [7:0]  m_ptr, m_lo, m_addr;
  logic [15:0] m_data;
  logic        m_we;
  logic [23:0] wlog[$];

  typedef struct {
    bit wr; bit [1:0] rg; bit [7:0] d;
    bit rq; bit [7:0] da; bit [15:0] dd;
    bit ack; bit we; bit [7:0] a; bit [15:0] dt;
    bit [7:0] p; bit b;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_ack();
    return rst_n && dma_req
        && !(cpu_wr && cpu_reg == 2'd2)
        && (mq.size() <= DEPTH - 2);
  endfunction

  task automatic model_edge();
    logic [23:0] e;
    bit a;
    if (!rst_n) begin
      mq.delete();
      m_ptr = 0; m_lo = 0; m_we = 0;
      m_addr = 0; m_data = 0;
    end else begin
      a = m_ack();
      m_we = 0;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1;
        m_addr = e[23:16];
        m_data = e[15:0];
      end
      if (cpu_wr) begin
        case (cpu_reg)
          2'd0: m_ptr = cpu_data;
          2'd1: m_lo = cpu_data;
          2'd2: begin
            mq.push_back({m_ptr, cpu_data, m_lo});
            if (AUTO) m_ptr = m_ptr + 8'd1;
          end
          default: ;
        endcase
      end
      if (a) mq.push_back({dma_addr, dma_data});
    end
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    #1;
    chk("dma_ack", dma_ack, m_ack());
    @(posedge clk);
    model_edge();
    #1;
    chk("cram_we", cram_we, m_we);
    chk("cram_addr", cram_addr, m_addr);
    chk("cram_data", cram_data, m_data);
    chk("ptr", ptr, m_ptr);
    chk("busy", busy, (mq.size() > 0) || m_we);
    if (cram_we) wlog.push_back({cram_addr, cram_data});
    @(negedge clk);
  endtask

  task automatic drive(input bit wr, input bit [1:0] rg,
                       input bit [7:0] d, input bit rq,
                       input bit [7:0] da, input bit [15:0] dd);
    cpu_wr = wr; cpu_reg = rg; cpu_data = d;
    dma_req = rq; dma_addr = da; dma_data = dd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit [7:0] p1, p2, p3;
    bit a;

    p1 = AUTO ? 8'h11 : 8'h10;
    p2 = AUTO ? 8'h12 : 8'h10;
    p3 = AUTO ? 8'h13 : 8'h10;
    tv.push_back('{1,0,8'h10, 0,0,0,     0,0,8'h00,16'h0000,8'h10,0});
    tv.push_back('{1,1,8'h34, 0,0,0,     0,0,8'h00,16'h0000,8'h10,0});
    tv.push_back('{1,2,8'h12, 0,0,0,     0,0,8'h00,16'h0000,p1,1});
    tv.push_back('{0,0,0,     0,0,0,     0,1,8'h10,16'h1234,p1,1});
    tv.push_back('{0,0,0,     0,0,0,     0,0,8'h10,16'h1234,p1,0});
    tv.push_back('{1,3,8'h55, 0,0,0,     0,0,8'h10,16'h1234,p1,0});
    tv.push_back('{1,2,8'h77, 0,0,0,     0,0,8'h10,16'h1234,p2,1});
    tv.push_back('{0,0,0,     0,0,0,     0,1,p1,16'h7734,p2,1});
    tv.push_back('{1,2,8'h99, 1,8'h40,16'hBEEF,
                   0,0,p1,16'h7734,p3,1});
    tv.push_back('{0,0,0,     1,8'h40,16'hBEEF,
                   1,1,p2,16'h9934,p3,1});
    tv.push_back('{0,0,0,     0,0,0,     0,1,8'h40,16'hBEEF,p3,1});
    tv.push_back('{0,0,0,     0,0,0,     0,0,8'h40,16'hBEEF,p3,0});

    // reset, with a DMA request pending to show ack is held low
    rst_n = 0;
    drive(0, 0, 0, 1, 8'h5A, 16'h5A5A);
    @(negedge clk);
    step();
    step();
    chk("rst dma_ack", dma_ack, 0);
    chk("rst cram_we", cram_we, 0);
    chk("rst busy", busy, 0);
    chk("rst ptr", ptr, 0);
    chk("rst addr", cram_addr, 0);
    chk("rst data", cram_data, 0);
    rst_n = 1;
    idle();
    step();

    foreach (tv[i]) begin
      drive(tv[i].wr, tv[i].rg, tv[i].d,
            tv[i].rq, tv[i].da, tv[i].dd);
      #1;
      chk($sformatf("tv%0d ack", i), dma_ack, tv[i].ack);
      step();
      chk($sformatf("tv%0d we", i), cram_we, tv[i].we);
      chk($sformatf("tv%0d addr", i), cram_addr, tv[i].a);
      chk($sformatf("tv%0d data", i), cram_data, tv[i].dt);
      chk($sformatf("tv%0d ptr", i), ptr, tv[i].p);
      chk($sformatf("tv%0d busy", i), busy, tv[i].b);
    end

    // pointer wrap at 0xFF
    wlog.delete();
    drive(1, 0, 8'hFF, 0, 0, 0); step();
    drive(1, 1, 8'h01, 0, 0, 0); step();
    drive(1, 2, 8'hAA, 0, 0, 0); step();
    drive(1, 2, 8'hBB, 0, 0, 0); step();
    idle(); step(); step(); step();
    chk("wrap count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("wrap w0", wlog[0], {8'hFF, 16'hAA01});
      chk("wrap w1", wlog[1],
          {(AUTO ? 8'h00 : 8'hFF), 16'hBB01});
    end
    chk("wrap ptr", ptr, AUTO ? 8'h01 : 8'hFF);

    // 8-word DMA burst
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 8'(8'h20 + i), 16'(16'hC000 + i));
      #1;
      chk("burst ack", dma_ack, 1);
      step();
    end
    idle(); step(); step(); step();
    chk("burst count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("burst word", wlog[i],
          {8'(8'h20 + i), 16'(16'hC000 + i)});
    end

    // reset while entries are in flight
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 8'(8'h60 + i), 16'(16'h6000 + i));
      step();
    end
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    wlog.delete();
    step(); step(); step();
    chk("rst-mid writes", wlog.size(), 0);
    chk("rst-mid busy", busy, 0);
    chk("rst-mid ptr", ptr, 0);

    // random traffic
    idle();
    for (int n = 0; n < 2000; n++) begin
      cpu_wr = ($urandom_range(0, 2) == 0);
      cpu_reg = 2'($urandom_range(0, 3));
      cpu_data = 8'($urandom);
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1;
        dma_addr = 8'($urandom);
        dma_data = 16'($urandom);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      #1;
      a = m_ack();
      step();
      if (a) dma_req = 0;
    end
    rst_n = 1;
    idle();
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
